// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed active-low 7-seg scanner: guard/show per digit, frame = 2*(DWELL+GUARD) cycles.
// Moore outputs from registered state; in_ready drops while a value is pending, and the value is committed at the frame boundary.
module seg_scan_driver #(
   parameter int DWELL    = 4,
   parameter int GUARD    = 1,
   parameter bit LZ_BLANK = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       segsel,
   output logic [6:0] segval,
   output logic       frame_done
);

   localparam int CMAX = (DWELL > GUARD) ? ((DWELL > 2) ? DWELL : 2)
                                         : ((GUARD > 2) ? GUARD : 2);
   localparam int CW = $clog2(CMAX);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);

   typedef enum logic [1:0] {S_LO_GUARD, S_LO_SHOW, S_HI_GUARD, S_HI_SHOW} state_t;
   localparam state_t S_RESET = (GUARD == 0) ? S_LO_SHOW : S_LO_GUARD;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [7:0]    disp, pend;
   logic          pend_full;
   logic          last;
   state_t        tgt;

   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'h0: enc = 7'h40;  4'h1: enc = 7'h79;  4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
         4'h4: enc = 7'h19;  4'h5: enc = 7'h12;  4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
         4'h8: enc = 7'h00;  4'h9: enc = 7'h10;  4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
         4'hC: enc = 7'h46;  4'hD: enc = 7'h21;  4'hE: enc = 7'h06;  4'hF: enc = 7'h0E;
         default: enc = 7'h7F;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_RESET;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Guard states are skipped entirely when GUARD == 0.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      last      = 1'b0;
      tgt       = state;
      case (state)
         S_LO_GUARD: begin last = (cnt == GUARD_LAST); tgt = S_LO_SHOW; end
         S_LO_SHOW:  begin last = (cnt == DWELL_LAST); tgt = (GUARD == 0) ? S_HI_SHOW : S_HI_GUARD; end
         S_HI_GUARD: begin last = (cnt == GUARD_LAST); tgt = S_HI_SHOW; end
         S_HI_SHOW:  begin last = (cnt == DWELL_LAST); tgt = (GUARD == 0) ? S_LO_SHOW : S_LO_GUARD; end
         default:    begin last = 1'b1; tgt = S_RESET; end
      endcase
      if (last) begin
         state_nxt = tgt;
         cnt_nxt   = '0;
      end
   end

   always_comb begin
      segsel     = (state == S_HI_GUARD) || (state == S_HI_SHOW);
      segval     = 7'h7F;
      frame_done = (state == S_HI_SHOW) && (cnt == DWELL_LAST);
      case (state)
         S_LO_SHOW: segval = enc(disp[3:0]);
         S_HI_SHOW: segval = (LZ_BLANK && disp[7:4] == 4'h0) ? 7'h7F : enc(disp[7:4]);
         default:   segval = 7'h7F;
      endcase
   end

   // Commit needs pend_full and accept needs !pend_full, so the two never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp      <= 8'h00;
         pend      <= 8'h00;
         pend_full <= 1'b0;
      end else if (frame_done && pend_full) begin
         disp      <= pend;
         pend_full <= 1'b0;
      end else if (in_valid && !pend_full) begin
         pend      <= in_data;
         pend_full <= 1'b1;
      end
   end

   assign in_ready = ~pend_full;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (DWELL=4, GUARD=1): a plain and a leading-zero-blanking instance share stimulus.
// Queue scoreboard holds accepted values until the frame boundary that should commit them.
module tb_seg_scan_driver;

   localparam int FRAME = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready, segsel, frame_done;
   logic [6:0] segval;
   logic       lz_ready, lz_sel, lz_fd;
   logic [6:0] lz_val;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   logic [7:0] exp_disp = 8'h00;
   logic [7:0] sb[$];
   logic [6:0] enc_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_scan_driver #(.DWELL(4), .GUARD(1), .LZ_BLANK(1'b0)) u_main (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .segsel(segsel), .segval(segval), .frame_done(frame_done));

   seg_scan_driver #(.DWELL(4), .GUARD(1), .LZ_BLANK(1'b1)) u_lz (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(lz_ready), .segsel(lz_sel), .segval(lz_val), .frame_done(lz_fd));

   always #5 clk = ~clk;

   // Expected {in_ready, frame_done, segsel, segval} at frame position p.
   function automatic logic [9:0] exp_vec(int p, logic [7:0] d, bit lz, bit rdy);
      logic [6:0] s;
      if (p == 0 || p == 5)  s = 7'h7F;
      else if (p < 5)        s = enc_tab[d[3:0]];
      else if (lz && d[7:4] == 4'h0) s = 7'h7F;
      else                   s = enc_tab[d[7:4]];
      return {rdy, (p == 9), (p >= 5), s};
   endfunction

   task automatic tick();
      bit         commit, accept;
      logic [7:0] d;
      d      = in_data;
      commit = !rst && (cyc % FRAME == FRAME - 1) && (sb.size() != 0);
      accept = !rst && in_valid && (sb.size() == 0);
      @(posedge clk);
      #1;
      if (rst) begin
         sb.delete();
         exp_disp = 8'h00;
         cyc = 0;
      end else begin
         if (commit) exp_disp = sb.pop_front();
         if (accept) sb.push_back(d);
         cyc++;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] e;
      apply_reset();
      for (int c = 0; c <= 10; c++) begin
         e = {1'b1, (cyc == 9), (cyc >= 5 && cyc <= 9), ((cyc % 5) == 0) ? 7'h7F : 7'h40};
         vectors++;
         if ({in_ready, frame_done, segsel, segval} !== e) begin
            miscompares++;
            $display("FAIL reset_main cyc%0d got %h want %h", cyc, {in_ready, frame_done, segsel, segval}, e);
         end
         e = exp_vec(cyc % FRAME, exp_disp, 1'b1, sb.size() == 0);
         vectors++;
         if ({lz_ready, lz_fd, lz_sel, lz_val} !== e) begin
            miscompares++;
            $display("FAIL reset_lz cyc%0d got %h want %h", cyc, {lz_ready, lz_fd, lz_sel, lz_val}, e);
         end
         tick();
      end
   endtask

   task automatic test_accept();
      logic [9:0] e;
      apply_reset();
      for (int c = 0; c <= 20; c++) begin
         in_valid = (cyc == 2);
         in_data  = 8'hA7;
         e = exp_vec(cyc % FRAME, exp_disp, 1'b0, sb.size() == 0);
         vectors++;
         if ({in_ready, frame_done, segsel, segval} !== e) begin
            miscompares++;
            $display("FAIL accept_main cyc%0d got %h want %h", cyc, {in_ready, frame_done, segsel, segval}, e);
         end
         e = exp_vec(cyc % FRAME, exp_disp, 1'b1, sb.size() == 0);
         vectors++;
         if ({lz_ready, lz_fd, lz_sel, lz_val} !== e) begin
            miscompares++;
            $display("FAIL accept_lz cyc%0d got %h want %h", cyc, {lz_ready, lz_fd, lz_sel, lz_val}, e);
         end
         if (cyc == 3) begin vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL accept_rdy_low cyc3 got %b want 0", in_ready); end end
         if (cyc == 10) begin vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL accept_rdy_high cyc10 got %b want 1", in_ready); end end
         if (cyc == 12) begin vectors++; if (segval !== 7'h78) begin miscompares++; $display("FAIL accept_lo cyc12 got %h want 78", segval); end end
         if (cyc == 17) begin vectors++; if (segval !== 7'h08) begin miscompares++; $display("FAIL accept_hi cyc17 got %h want 08", segval); end end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [9:0] e;
      apply_reset();
      for (int c = 0; c <= 29; c++) begin
         in_valid = (cyc >= 1 && cyc <= 10);
         in_data  = (cyc == 1) ? 8'h12 : 8'h3C;
         e = exp_vec(cyc % FRAME, exp_disp, 1'b0, sb.size() == 0);
         vectors++;
         if ({in_ready, frame_done, segsel, segval} !== e) begin
            miscompares++;
            $display("FAIL backpressure_main cyc%0d got %h want %h", cyc, {in_ready, frame_done, segsel, segval}, e);
         end
         e = exp_vec(cyc % FRAME, exp_disp, 1'b1, sb.size() == 0);
         vectors++;
         if ({lz_ready, lz_fd, lz_sel, lz_val} !== e) begin
            miscompares++;
            $display("FAIL backpressure_lz cyc%0d got %h want %h", cyc, {lz_ready, lz_fd, lz_sel, lz_val}, e);
         end
         if (cyc == 5) begin vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_rdy cyc5 got %b want 0", in_ready); end end
         if (cyc == 12) begin vectors++; if (segval !== 7'h24) begin miscompares++; $display("FAIL bp_first_lo cyc12 got %h want 24", segval); end end
         if (cyc == 22) begin vectors++; if (segval !== 7'h46) begin miscompares++; $display("FAIL bp_second_lo cyc22 got %h want 46", segval); end end
         if (cyc == 27) begin vectors++; if (segval !== 7'h30) begin miscompares++; $display("FAIL bp_second_hi cyc27 got %h want 30", segval); end end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_boundary_accept();
      logic [9:0] e;
      apply_reset();
      for (int c = 0; c <= 29; c++) begin
         in_valid = (cyc == 9);
         in_data  = 8'h5E;
         e = exp_vec(cyc % FRAME, exp_disp, 1'b0, sb.size() == 0);
         vectors++;
         if ({in_ready, frame_done, segsel, segval} !== e) begin
            miscompares++;
            $display("FAIL boundary_main cyc%0d got %h want %h", cyc, {in_ready, frame_done, segsel, segval}, e);
         end
         e = exp_vec(cyc % FRAME, exp_disp, 1'b1, sb.size() == 0);
         vectors++;
         if ({lz_ready, lz_fd, lz_sel, lz_val} !== e) begin
            miscompares++;
            $display("FAIL boundary_lz cyc%0d got %h want %h", cyc, {lz_ready, lz_fd, lz_sel, lz_val}, e);
         end
         if (cyc == 12) begin vectors++; if (segval !== 7'h40) begin miscompares++; $display("FAIL bnd_hold_lo cyc12 got %h want 40", segval); end end
         if (cyc == 17) begin vectors++; if (segval !== 7'h40) begin miscompares++; $display("FAIL bnd_hold_hi cyc17 got %h want 40", segval); end end
         if (cyc == 22) begin vectors++; if (segval !== 7'h06) begin miscompares++; $display("FAIL bnd_lo cyc22 got %h want 06", segval); end end
         if (cyc == 27) begin vectors++; if (segval !== 7'h12) begin miscompares++; $display("FAIL bnd_hi cyc27 got %h want 12", segval); end end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_lz_blank();
      logic [9:0] e;
      apply_reset();
      for (int c = 0; c <= 29; c++) begin
         in_valid = (cyc == 1) || (cyc == 11);
         in_data  = (cyc < 10) ? 8'h09 : 8'h19;
         e = exp_vec(cyc % FRAME, exp_disp, 1'b0, sb.size() == 0);
         vectors++;
         if ({in_ready, frame_done, segsel, segval} !== e) begin
            miscompares++;
            $display("FAIL lz_main cyc%0d got %h want %h", cyc, {in_ready, frame_done, segsel, segval}, e);
         end
         e = exp_vec(cyc % FRAME, exp_disp, 1'b1, sb.size() == 0);
         vectors++;
         if ({lz_ready, lz_fd, lz_sel, lz_val} !== e) begin
            miscompares++;
            $display("FAIL lz_lz cyc%0d got %h want %h", cyc, {lz_ready, lz_fd, lz_sel, lz_val}, e);
         end
         if (cyc == 12) begin vectors++; if (lz_val !== 7'h10) begin miscompares++; $display("FAIL lz_lo cyc12 got %h want 10", lz_val); end end
         if (cyc == 17) begin vectors++; if (lz_val !== 7'h7F) begin miscompares++; $display("FAIL lz_blank cyc17 got %h want 7F", lz_val); end end
         if (cyc == 17) begin vectors++; if (segval !== 7'h40) begin miscompares++; $display("FAIL lz_noblank cyc17 got %h want 40", segval); end end
         if (cyc == 27) begin vectors++; if (lz_val !== 7'h79) begin miscompares++; $display("FAIL lz_hi cyc27 got %h want 79", lz_val); end end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [9:0] e;
      bit         hit = 1'b0;
      apply_reset();
      for (int c = 0; c < 30; c++) begin
         in_valid = !hit && (cyc == 6);
         in_data  = 8'hFF;
         rst      = !hit && (cyc == 7);
         if (hit && cyc == 0) begin
            vectors++;
            if ({in_ready, segsel, segval} !== {1'b1, 1'b0, 7'h7F}) begin
               miscompares++;
               $display("FAIL rstmid_state got %h want %h", {in_ready, segsel, segval}, {1'b1, 1'b0, 7'h7F});
            end
         end
         e = exp_vec(cyc % FRAME, exp_disp, 1'b0, sb.size() == 0);
         vectors++;
         if ({in_ready, frame_done, segsel, segval} !== e) begin
            miscompares++;
            $display("FAIL rstmid_main cyc%0d got %h want %h", cyc, {in_ready, frame_done, segsel, segval}, e);
         end
         e = exp_vec(cyc % FRAME, exp_disp, 1'b1, sb.size() == 0);
         vectors++;
         if ({lz_ready, lz_fd, lz_sel, lz_val} !== e) begin
            miscompares++;
            $display("FAIL rstmid_lz cyc%0d got %h want %h", cyc, {lz_ready, lz_fd, lz_sel, lz_val}, e);
         end
         if (hit && (cyc == 12 || cyc == 17)) begin
            vectors++;
            if (segval !== 7'h40) begin miscompares++; $display("FAIL rstmid_discard cyc%0d got %h want 40", cyc, segval); end
         end
         if (rst) hit = 1'b1;
         tick();
      end
      rst = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_accept();
      test_backpressure();
      test_boundary_accept();
      test_lz_blank();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
